// File: rtl/ex_mem_stage_pkg.sv
// Shared decode constants for the EX->MEM stage.
// Opcode/funct values and the instruction field positions used by result selection.
// Also holds the occupancy state type of the elastic stage.
package ex_mem_stage_pkg;

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  // Opcode / funct values that redirect the stored result
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Number of buffered entries: none, head only, head + skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side and MEM-side handshake/payload bundle of the EX->MEM stage.
// master: the pipeline around the stage (drives EX payload, valid_E, ready_M).
// slave:  the stage itself (drives ready_E, valid_M and the MEM payload).
interface ex_mem_stage_if #(
  parameter int DW = 32
);

  logic          valid_E;
  logic          ready_E;
  logic [DW-1:0] ins_E;
  logic [DW-1:0] pc_E;
  logic [DW-1:0] RData2_E;
  logic [DW-1:0] alu_Result_E;
  logic [DW-1:0] HI_E;
  logic [DW-1:0] LO_E;

  logic          valid_M;
  logic          ready_M;
  logic [DW-1:0] ins_M;
  logic [DW-1:0] pc_M;
  logic [DW-1:0] RData2_M;
  logic [DW-1:0] alu_Result_M;

  modport master (
    output valid_E, ins_E, pc_E, RData2_E, alu_Result_E, HI_E, LO_E, ready_M,
    input  ready_E, valid_M, ins_M, pc_M, RData2_M, alu_Result_M
  );

  modport slave (
    input  valid_E, ins_E, pc_E, RData2_E, alu_Result_E, HI_E, LO_E, ready_M,
    output ready_E, valid_M, ins_M, pc_M, RData2_M, alu_Result_M
  );

endinterface

// File: rtl/ex_result_sel.sv
// Picks the value an EX entry carries into MEM: link address, HI, LO or ALU result.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: op/fn = instruction opcode and funct fields; pc, alu, hi, lo = candidates;
//        result = selected value.
module ex_result_sel
  import ex_mem_stage_pkg::*;
#(
  parameter int DW          = 32,
  parameter int LINK_OFFSET = 0
) (
  input  logic [5:0]    op,
  input  logic [5:0]    fn,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] alu,
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  output logic [DW-1:0] result
);

  // Link value wraps modulo 2^DW
  logic [DW-1:0] link;
  assign link = pc + DW'(LINK_OFFSET);

  always_comb begin
    result = alu;
    if (op == OP_JAL) begin
      result = link;
    end else if (op == OP_RTYPE) begin
      case (fn)
        FN_JALR: result = link;
        FN_MFHI: result = hi;
        FN_MFLO: result = lo;
        default: result = alu;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Elastic EX->MEM pipeline register with a 2-entry skid buffer and result selection.
// Latency: 1 cycle accept-to-valid_M when empty; 1 entry/cycle with ready_M held high.
// Backpressure: ready_E is registered and drops only when both entries are full.
// Ports: clk, rst (async active-low), flush (sync, drops all entries), bus (slave side:
//        EX valid/ready/payload in, MEM valid/ready/payload out), stall_cnt (saturating
//        count of cycles with valid_M=1 and ready_M=0). DW must match the bus instance.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DW          = 32,
  parameter int LINK_OFFSET = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ex_mem_stage_if.slave          bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DW-1:0] ins;
    logic [DW-1:0] pc;
    logic [DW-1:0] rdata2;
    logic [DW-1:0] result;
  } entry_t;

  stage_state_e  state, state_nxt;
  entry_t        head, head_nxt;
  entry_t        skid, skid_nxt;
  entry_t        new_entry;
  logic [DW-1:0] sel_result;
  logic          ready_q;
  logic          valid_m;
  logic          accept;
  logic          issue;

  ex_result_sel #(
    .DW          (DW),
    .LINK_OFFSET (LINK_OFFSET)
  ) u_result_sel (
    .op     (bus.ins_E[OP_MSB:OP_LSB]),
    .fn     (bus.ins_E[FN_MSB:FN_LSB]),
    .pc     (bus.pc_E),
    .alu    (bus.alu_Result_E),
    .hi     (bus.HI_E),
    .lo     (bus.LO_E),
    .result (sel_result)
  );

  assign new_entry = '{ins: bus.ins_E, pc: bus.pc_E, rdata2: bus.RData2_E, result: sel_result};

  assign valid_m = (state != EMPTY);
  assign accept  = bus.valid_E & ready_q;
  assign issue   = valid_m & bus.ready_M;

  // Head is cleared whenever the stage empties, so an idle stage presents
  // an all-zero payload (ins 0 reads as a nop bubble).
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    case (state)
      EMPTY: begin
        if (accept) begin
          head_nxt  = new_entry;
          state_nxt = ONE;
        end
      end
      ONE: begin
        case ({accept, issue})
          2'b10: begin
            skid_nxt  = new_entry;
            state_nxt = TWO;
          end
          2'b01: begin
            head_nxt  = '0;
            state_nxt = EMPTY;
          end
          2'b11:   head_nxt = new_entry;
          default: ;
        endcase
      end
      TWO: begin
        // ready_E is low here, so no accept can coincide with the issue
        if (issue) begin
          head_nxt  = skid;
          skid_nxt  = '0;
          state_nxt = ONE;
        end
      end
      default: begin
        head_nxt  = '0;
        skid_nxt  = '0;
        state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      head_nxt  = '0;
      skid_nxt  = '0;
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      head    <= head_nxt;
      skid    <= skid_nxt;
      ready_q <= (state_nxt != TWO);
    end
  end

  // Flush deliberately leaves the counter alone; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (valid_m && !bus.ready_M && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.ready_E      = ready_q;
  assign bus.valid_M      = valid_m;
  assign bus.ins_M        = head.ins;
  assign bus.pc_M         = head.pc;
  assign bus.RData2_M     = head.rdata2;
  assign bus.alu_Result_M = head.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: dut0 (LINK_OFFSET=8, 16-bit counter) and
// dut1 (LINK_OFFSET=0, 4-bit counter). Expected entries are queued on accept and
// popped/compared by per-DUT monitors on every issue.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] rd2;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush0 = 1'b0;
  logic        flush1 = 1'b0;
  logic [15:0] stall0;
  logic [3:0]  stall1;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DW(32)) bus0 ();
  ex_mem_stage_if #(.DW(32)) bus1 ();

  ex_mem_stage #(.DW(32), .LINK_OFFSET(8), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .bus(bus0), .stall_cnt(stall0)
  );

  ex_mem_stage #(.DW(32), .LINK_OFFSET(0), .STALL_CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(bus1), .stall_cnt(stall1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst && bus0.valid_M && bus0.ready_M) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected issue pc", bus0.pc_M, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 ins_M", bus0.ins_M, e.ins);
        check("dut0 pc_M", bus0.pc_M, e.pc);
        check("dut0 RData2_M", bus0.RData2_M, e.rd2);
        check("dut0 alu_Result_M", bus0.alu_Result_M, e.res);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bus1.valid_M && bus1.ready_M) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected issue pc", bus1.pc_M, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 ins_M", bus1.ins_M, e.ins);
        check("dut1 pc_M", bus1.pc_M, e.pc);
        check("dut1 RData2_M", bus1.RData2_M, e.rd2);
        check("dut1 alu_Result_M", bus1.alu_Result_M, e.res);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_valid(input int d, input logic v);
    if (d == 0) bus0.valid_E = v;
    else        bus1.valid_E = v;
  endtask

  task automatic put(input int d, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] rd2, input logic [31:0] alu,
                     input logic [31:0] hi, input logic [31:0] lo);
    if (d == 0) begin
      bus0.ins_E = ins; bus0.pc_E = pc; bus0.RData2_E = rd2;
      bus0.alu_Result_E = alu; bus0.HI_E = hi; bus0.LO_E = lo;
    end else begin
      bus1.ins_E = ins; bus1.pc_E = pc; bus1.RData2_E = rd2;
      bus1.alu_Result_E = alu; bus1.HI_E = hi; bus1.LO_E = lo;
    end
  endtask

  // Offers one entry, waits (bounded) for the accepting edge, queues its expectation.
  // Returns #1 after the accepting edge with valid_E dropped.
  task automatic send(input int d, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] rd2, input logic [31:0] alu,
                      input logic [31:0] hi, input logic [31:0] lo,
                      input logic [31:0] exp_res);
    bit   done;
    exp_t e;
    done = 0;
    e = '{ins: ins, pc: pc, rd2: rd2, res: exp_res};
    put(d, ins, pc, rd2, alu, hi, lo);
    set_valid(d, 1'b1);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((d == 0) ? bus0.ready_E : bus1.ready_E) begin
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    set_valid(d, 1'b0);
    if (!done) check("send accept timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] s;
    bus0.valid_E = 0; bus0.ready_M = 1;
    bus1.valid_E = 0; bus1.ready_M = 1;
    put(0, 0, 0, 0, 0, 0, 0);
    put(1, 0, 0, 0, 0, 0, 0);

    // Reset state
    #2 rst = 1'b0;
    #2;
    check("reset valid_M", {31'd0, bus0.valid_M}, 32'd0);
    check("reset ready_E", {31'd0, bus0.ready_E}, 32'd1);
    check("reset ins_M", bus0.ins_M, 32'd0);
    check("reset alu_Result_M", bus0.alu_Result_M, 32'd0);
    check("reset stall_cnt", {16'd0, stall0}, 32'd0);
    @(negedge clk) rst = 1'b1;
    cycles(1);

    // Result selection, LINK_OFFSET=8
    send(0, 32'h0C000010, 32'h00003000, 32'h0000AAAA, 32'h00001111, 32'h0, 32'h0, 32'h00003008); // jal
    check("latency valid_M", {31'd0, bus0.valid_M}, 32'd1);
    check("latency pc_M", bus0.pc_M, 32'h00003000);
    send(0, 32'h00000010, 32'h00003004, 32'h0, 32'h00002222, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF); // mfhi
    send(0, 32'h00000012, 32'h00003008, 32'h0, 32'h00003333, 32'h0, 32'h12345678, 32'h12345678); // mflo
    send(0, 32'h00400009, 32'h0000300C, 32'h0, 32'h00004444, 32'h0, 32'h0, 32'h00003014); // jalr
    send(0, 32'h00221820, 32'h00003010, 32'h5, 32'h00005555, 32'h1, 32'h2, 32'h00005555); // add
    send(0, 32'h8C000010, 32'h00003014, 32'h0, 32'h00006666, 32'h7, 32'h8, 32'h00006666); // lw, funct bits look like mfhi
    send(0, 32'h0C000000, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000004); // jal link wraps
    cycles(3);

    // Result selection, LINK_OFFSET=0
    send(1, 32'h0C000010, 32'h00003000, 32'h0, 32'h00001111, 32'h0, 32'h0, 32'h00003000);
    send(1, 32'h00000010, 32'h00003004, 32'h0, 32'h00002222, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    send(1, 32'h00000012, 32'h00003008, 32'h0, 32'h00003333, 32'h0, 32'h12345678, 32'h12345678);
    send(1, 32'h00000009, 32'h0000300C, 32'h0, 32'h00004444, 32'h0, 32'h0, 32'h0000300C);
    cycles(3);

    // Back-pressure: A then B with ready_M low
    bus0.ready_M = 0;
    s = stall0;
    send(0, 32'h000000A0, 32'h0000A000, 32'hA, 32'hA0A0A0A0, 0, 0, 32'hA0A0A0A0);
    send(0, 32'h000000B0, 32'h0000B000, 32'hB, 32'hB0B0B0B0, 0, 0, 32'hB0B0B0B0);
    check("bp ready_E low in TWO", {31'd0, bus0.ready_E}, 32'd0);
    check("bp head is A", bus0.pc_M, 32'h0000A000);
    check("bp stall +1", {16'd0, stall0}, {16'd0, s + 16'd1});
    s = stall0;
    cycles(3);
    check("bp stall +3", {16'd0, stall0}, {16'd0, s + 16'd3});
    check("bp ready_E held low", {31'd0, bus0.ready_E}, 32'd0);
    bus0.ready_M = 1;
    cycles(1);
    check("bp B next", bus0.pc_M, 32'h0000B000);
    check("bp B valid", {31'd0, bus0.valid_M}, 32'd1);
    cycles(1);
    check("bp drained", {31'd0, bus0.valid_M}, 32'd0);
    check("bp stall frozen", {16'd0, stall0}, {16'd0, s + 16'd3});

    // Full throughput
    s = stall0;
    for (int i = 0; i < 100; i++) begin
      send(0, 32'h0, 32'h1000 + 32'(4 * i), 32'(i), 32'hA000 + 32'(i), 0, 0, 32'hA000 + 32'(i));
      check("tp pc_M", bus0.pc_M, 32'h1000 + 32'(4 * i));
      check("tp ready_E", {31'd0, bus0.ready_E}, 32'd1);
    end
    cycles(2);
    check("tp stall unchanged", {16'd0, stall0}, {16'd0, s});

    // Flush in TWO with entry C offered
    bus0.ready_M = 0;
    send(0, 32'h000000C1, 32'h0000C100, 0, 32'hC1, 0, 0, 32'hC1);
    send(0, 32'h000000D1, 32'h0000D100, 0, 32'hD1, 0, 0, 32'hD1);
    s = stall0;
    put(0, 32'h000000CC, 32'h0000CC00, 0, 32'hCC, 0, 0);
    bus0.valid_E = 1;
    flush0 = 1;
    q0.delete();
    cycles(1);
    flush0 = 0;
    bus0.valid_E = 0;
    check("flush valid_M", {31'd0, bus0.valid_M}, 32'd0);
    check("flush ready_E", {31'd0, bus0.ready_E}, 32'd1);
    check("flush ins_M", bus0.ins_M, 32'd0);
    check("flush alu_Result_M", bus0.alu_Result_M, 32'd0);
    check("flush keeps stall", {16'd0, stall0}, {16'd0, s + 16'd1});
    bus0.ready_M = 1;
    cycles(3);
    send(0, 32'h000000E0, 32'h0000E000, 32'hE, 32'hE0, 0, 0, 32'hE0);
    cycles(3);

    // Asynchronous reset while in TWO
    bus0.ready_M = 0;
    send(0, 32'h000000F1, 32'h0000F100, 0, 32'hF1, 0, 0, 32'hF1);
    send(0, 32'h000000F2, 32'h0000F200, 0, 32'hF2, 0, 0, 32'hF2);
    #2 rst = 1'b0;
    #1;
    check("arst valid_M", {31'd0, bus0.valid_M}, 32'd0);
    check("arst ready_E", {31'd0, bus0.ready_E}, 32'd1);
    check("arst pc_M", bus0.pc_M, 32'd0);
    check("arst RData2_M", bus0.RData2_M, 32'd0);
    check("arst stall_cnt", {16'd0, stall0}, 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk) rst = 1'b1;
    bus0.ready_M = 1;
    cycles(1);

    // Saturation on 4-bit counter
    bus1.ready_M = 0;
    send(1, 32'h00000051, 32'h00005100, 0, 32'h51, 0, 0, 32'h51);
    cycles(5);
    check("sat stall 5", {28'd0, stall1}, 32'd5);
    cycles(15);
    check("sat stall 15", {28'd0, stall1}, 32'd15);
    cycles(5);
    check("sat stall held", {28'd0, stall1}, 32'd15);
    bus1.ready_M = 1;
    cycles(3);

    check("q0 drained", q0.size(), 32'd0);
    check("q1 drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
